// File: rtl/map_speed_controller_pkg.sv
// Shared definitions for the map scroll speed controller: FSM encoding,
// default timing constants and the period lookup.
package map_speed_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned BASE_PERIOD_DEF = 32'd800;
  localparam int unsigned STEP_DEF        = 32'd100;
  localparam int unsigned LEVEL_TICKS_DEF = 32'd30000;
  localparam int unsigned MAX_LEVEL_DEF   = 32'd3;
  localparam int unsigned CNT_W_DEF       = 32'd16;

  // Scroll period in ms ticks for a combined difficulty index 0..6.
  function automatic int unsigned period_f(input logic [2:0] idx,
                                           input int unsigned base_p,
                                           input int unsigned step_p);
    return base_p - step_p * 32'(idx);
  endfunction

endpackage

// File: rtl/map_speed_controller_if.sv
// Control/status bundle between the game FSM, the speed controller and the
// map renderer.
interface map_speed_controller_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic       count_map;
  logic [1:0] velocity;
  logic       move_map;
  logic [1:0] base_level;
  logic       max_level;
  logic       running;

  modport master (
    output start, pause, stop, count_map, velocity,
    input  move_map, base_level, max_level, running
  );

  modport slave (
    input  start, pause, stop, count_map, velocity,
    output move_map, base_level, max_level, running
  );
endinterface

// File: rtl/map_speed_controller_timer.sv
// Loadable mod-N counter: the modulus is captured on load and re-captured on
// every terminal tick, so a new modulus only applies to the following cycle.
module map_period_timer
  import map_speed_controller_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] mod_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] mod_r;

  assign tc = en && (cnt_r == (mod_r - CNT_W'(1)));

  // Count register and latched modulus.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r <= '0;
      mod_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
      mod_r <= '0;
    end else if (load || tc) begin
      cnt_r <= '0;
      mod_r <= mod_val;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/map_speed_controller.sv
// Map scroll sequencer: run/pause/stop FSM, one move_map pulse per period,
// period shortened by base level plus player velocity.
module map_speed_controller
  import map_speed_controller_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = BASE_PERIOD_DEF,
  parameter int unsigned STEP        = STEP_DEF,
  parameter int unsigned LEVEL_TICKS = LEVEL_TICKS_DEF,
  parameter int unsigned MAX_LEVEL   = MAX_LEVEL_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic                  clock,
  input logic                  reset,
  map_speed_controller_if.slave bus
);

  state_e           state_r, state_n;
  logic             load_s, clr_s, en_s;
  logic             per_tc_s, lvl_tc_s;
  logic [2:0]       idx_s;
  logic [CNT_W-1:0] period_s;
  logic [1:0]       base_level_r, base_level_n;
  logic             max_level_r, move_map_r, running_r;

  // Reload samples the pre-increment level, so a level step lands one period later.
  assign idx_s    = {1'b0, base_level_r} + {1'b0, bus.velocity};
  assign period_s = CNT_W'(period_f(idx_s, BASE_PERIOD, STEP));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and timer controls; stop wins over start and pause.
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_n = ST_IDLE;
          clr_s   = 1'b1;
        end else if (bus.pause) begin
          state_n = ST_PAUSE;
        end else begin
          state_n = ST_RUN;
          en_s    = bus.count_map;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_n = ST_IDLE;
          clr_s   = 1'b1;
        end else if (!bus.pause) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_PAUSE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        clr_s   = 1'b1;
      end
    endcase
  end

  // Saturating base level.
  always_comb begin
    base_level_n = base_level_r;
    if (clr_s) begin
      base_level_n = 2'd0;
    end else if (lvl_tc_s && (base_level_r < 2'(MAX_LEVEL))) begin
      base_level_n = base_level_r + 2'd1;
    end else begin
      base_level_n = base_level_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      base_level_r <= 2'd0;
      max_level_r  <= 1'b0;
      move_map_r   <= 1'b0;
      running_r    <= 1'b0;
    end else begin
      base_level_r <= base_level_n;
      max_level_r  <= (base_level_n == 2'(MAX_LEVEL));
      move_map_r   <= per_tc_s;
      running_r    <= (state_n == ST_RUN);
    end
  end

  map_period_timer #(.CNT_W(CNT_W)) u_period_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr_s),
    .load    (load_s),
    .en      (en_s),
    .mod_val (period_s),
    .tc      (per_tc_s)
  );

  map_period_timer #(.CNT_W(CNT_W)) u_level_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr_s),
    .load    (load_s),
    .en      (en_s),
    .mod_val (CNT_W'(LEVEL_TICKS)),
    .tc      (lvl_tc_s)
  );

  assign bus.move_map   = move_map_r;
  assign bus.base_level = base_level_r;
  assign bus.max_level  = max_level_r;
  assign bus.running    = running_r;

endmodule

// File: tb/tb_map_speed_controller.sv
// Directed bench for map_speed_controller. LEVEL_TICKS is scaled to 1600 so
// level steps, saturation and the wrap/terminal coincidence fit a short run.
module tb_map_speed_controller;

  logic clock = 1'b0;
  logic reset;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   tick_abs = 0;
  int   pulses   = 0;
  int   n;

  map_speed_controller_if bus ();

  map_speed_controller #(.LEVEL_TICKS(32'd1600)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_ticks(input int cnt);
    bus.count_map = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      step();
      tick_abs++;
      if (bus.move_map) pulses++;
    end
    bus.count_map = 1'b0;
  endtask

  task automatic run_to(input int t);
    run_ticks(t - tick_abs);
  endtask

  // Ticks until the next move_map pulse; 0 if none within 2000 ticks.
  task automatic until_pulse(output int ticks);
    ticks = 0;
    bus.count_map = 1'b1;
    for (int i = 1; i <= 2000; i++) begin
      step();
      tick_abs++;
      if (bus.move_map) begin
        pulses++;
        ticks = i;
        break;
      end
    end
    bus.count_map = 1'b0;
  endtask

  task automatic do_start();
    bus.start     = 1'b1;
    bus.count_map = 1'b0;
    step();
    bus.start = 1'b0;
    tick_abs  = 0;
    pulses    = 0;
  endtask

  task automatic do_stop(input logic cm);
    bus.stop      = 1'b1;
    bus.count_map = cm;
    step();
    bus.stop      = 1'b0;
    bus.count_map = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.stop      = 1'b0;
    bus.count_map = 1'b0;
    bus.velocity  = 2'd0;
    reset         = 1'b0;
    step();
    step();
    check_val("rst_move_map", 32'(bus.move_map), 32'd0);
    check_val("rst_base_level", 32'(bus.base_level), 32'd0);
    check_val("rst_max_level", 32'(bus.max_level), 32'd0);
    check_val("rst_running", 32'(bus.running), 32'd0);
    reset = 1'b1;
    step();
    check_val("idle_running", 32'(bus.running), 32'd0);

    // Velocity 0: period 800, level step every 1600 ticks.
    do_start();
    check_val("start_running", 32'(bus.running), 32'd1);
    run_to(799);
    check_val("no_pulse_before_800", 32'(pulses), 32'd0);
    run_to(800);
    check_val("pulse_at_800", 32'(bus.move_map), 32'd1);
    check_val("level0_at_800", 32'(bus.base_level), 32'd0);
    run_to(801);
    check_val("pulse_one_cycle", 32'(bus.move_map), 32'd0);
    run_to(1599);
    check_val("level0_at_1599", 32'(bus.base_level), 32'd0);
    run_to(1600);
    check_val("pulse_at_1600", 32'(bus.move_map), 32'd1);
    check_val("level1_at_1600", 32'(bus.base_level), 32'd1);
    until_pulse(n);
    check_val("coincide_old_level_period", 32'(n), 32'd800);
    until_pulse(n);
    check_val("new_level_period", 32'(n), 32'd700);
    run_to(3199);
    check_val("level1_at_3199", 32'(bus.base_level), 32'd1);
    run_to(3200);
    check_val("level2_at_3200", 32'(bus.base_level), 32'd2);
    run_to(4799);
    check_val("max0_at_4799", 32'(bus.max_level), 32'd0);
    run_to(4800);
    check_val("level3_at_4800", 32'(bus.base_level), 32'd3);
    check_val("max1_at_4800", 32'(bus.max_level), 32'd1);
    run_to(6401);
    check_val("level_saturated", 32'(bus.base_level), 32'd3);
    check_val("max_held", 32'(bus.max_level), 32'd1);
    until_pulse(n);
    until_pulse(n);
    check_val("level3_period", 32'(n), 32'd500);

    // Stop clears the level; velocity change mid-period applies next period.
    do_stop(1'b0);
    check_val("stop_base_level", 32'(bus.base_level), 32'd0);
    check_val("stop_max_level", 32'(bus.max_level), 32'd0);
    check_val("stop_running", 32'(bus.running), 32'd0);
    do_start();
    run_ticks(400);
    bus.velocity = 2'd3;
    until_pulse(n);
    check_val("vel_change_keeps_period", 32'(n), 32'd400);
    until_pulse(n);
    check_val("vel3_period", 32'(n), 32'd500);
    bus.velocity = 2'd0;

    // Pause freezes the period count.
    do_stop(1'b0);
    do_start();
    run_ticks(300);
    bus.pause = 1'b1;
    step();
    check_val("pause_running", 32'(bus.running), 32'd0);
    pulses = 0;
    run_ticks(1000);
    check_val("pause_no_pulse", 32'(pulses), 32'd0);
    bus.pause = 1'b0;
    step();
    check_val("resume_running", 32'(bus.running), 32'd1);
    until_pulse(n);
    check_val("resume_remaining", 32'(n), 32'd500);

    // Stop on the terminal tick suppresses the pulse.
    do_stop(1'b0);
    do_start();
    run_ticks(799);
    do_stop(1'b1);
    check_val("stop_terminal_move_map", 32'(bus.move_map), 32'd0);
    check_val("stop_terminal_running", 32'(bus.running), 32'd0);
    pulses = 0;
    run_ticks(50);
    check_val("idle_ignores_count", 32'(pulses), 32'd0);
    do_start();
    until_pulse(n);
    check_val("restart_full_period", 32'(n), 32'd800);

    // Reset on the terminal tick overrides everything.
    run_ticks(799);
    reset         = 1'b0;
    bus.count_map = 1'b1;
    step();
    check_val("reset_terminal_move_map", 32'(bus.move_map), 32'd0);
    check_val("reset_terminal_running", 32'(bus.running), 32'd0);
    check_val("reset_terminal_level", 32'(bus.base_level), 32'd0);
    reset         = 1'b1;
    bus.count_map = 1'b0;
    step();
    do_start();
    until_pulse(n);
    check_val("reset_restart_period", 32'(n), 32'd800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
